// File: rtl/dmem_pkg.sv
// Shared defaults for the data memory: word width, word-address width and derived depth.
package dmem_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DEPTH  = 2 ** DEF_ADDR_W;

endpackage : dmem_pkg

// File: rtl/dmem_ram.sv
// Word-addressed storage array: one synchronous write port, one combinational read port,
// and a whole-array clear that takes priority over the write.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_clr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Declaration initialiser gives all-zero contents at time zero.
  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // No write-to-read bypass: a same-cycle write is only visible after the edge.
  assign o_rdata = r_mem[i_addr];

endmodule : dmem_ram

// File: rtl/dmem.sv
// Data memory wrapper: read gating, write suppression during reset and, with
// DMEM_RST_CLEAR_EN defined, a reset-time clear of every word.
module dmem
  import dmem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic [DATA_W-1:0] read_data
);

  logic              w_we;
  logic              w_clr;
  logic [DATA_W-1:0] w_rdata;

  assign w_we = MemWrite & ~rst;

`ifdef DMEM_RST_CLEAR_EN
  assign w_clr = rst;
`else
  // Contents survive reset; reset only blocks the write.
  assign w_clr = 1'b0;
`endif

  dmem_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_clr   (w_clr),
    .i_addr  (addr),
    .i_wdata (write_data),
    .o_rdata (w_rdata)
  );

  // read_data has no reset value of its own; it only follows MemRead and the array.
  assign read_data = MemRead ? w_rdata : '0;

endmodule : dmem

// File: tb/tb_dmem.sv
// Self-checking bench for dmem: directed scenarios plus randomized traffic against
// a plain array model of the memory.
module tb_dmem;
  import dmem_pkg::*;

  localparam int DW = DEF_DATA_W;
  localparam int AW = DEF_ADDR_W;
  localparam int DEPTH = DEF_DEPTH;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] write_data = '0;
  logic          MemRead = 1'b0;
  logic          MemWrite = 1'b0;
  logic [DW-1:0] read_data;

  int n_checks = 0;
  int n_fail = 0;

  logic [DW-1:0] model [DEPTH];

  dmem #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .write_data (write_data),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .read_data  (read_data)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive after the falling edge, check the combinational read
  // before the rising edge, then apply the write/reset rules to the model.
  task automatic step(input logic r, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input logic rd, input logic we, input string tag);
    logic [DW-1:0] exp;
    @(negedge clk);
    rst = r; addr = a; write_data = wd; MemRead = rd; MemWrite = we;
    #1;
    exp = rd ? model[a] : '0;
    check_val(tag, read_data, exp);
    @(posedge clk);
    if (r) begin
`ifdef DMEM_RST_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
`endif
    end else if (we) begin
      model[a] = wd;
    end
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic          rr, rw, rrd;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    // Reset state: unwritten memory reads zero, also during reset.
    step(1'b1, 14'd0, 32'h0, 1'b1, 1'b0, "rst_read0");
    step(1'b1, 14'd7, 32'hFFFF_FFFF, 1'b1, 1'b1, "rst_read7");
    step(1'b0, 14'd7, 32'h0, 1'b1, 1'b0, "init_read7");

    // Write pass then read pass.
    for (int a = 0; a < 10; a++)
      step(1'b0, AW'(a), DW'(a * 2), 1'b0, 1'b1, "wr_pass");
    for (int a = 0; a < 10; a++) begin
      step(1'b0, AW'(a), 32'h0, 1'b1, 1'b0, "rd_pass");
      check_val("rd_pass_const", read_data, DW'(a * 2));
    end

    // Read disabled forces zero.
    step(1'b0, 14'd5, 32'h0, 1'b0, 1'b0, "rd_off");
    check_val("rd_off_const", read_data, 32'h0);

    // Top address and address 0 are distinct words.
    step(1'b0, 14'h3FFF, 32'hA5A5_A5A5, 1'b0, 1'b1, "wr_top");
    step(1'b0, 14'h3FFF, 32'h0, 1'b1, 1'b0, "rd_top");
    check_val("rd_top_const", read_data, 32'hA5A5_A5A5);
    step(1'b0, 14'h0000, 32'h0, 1'b1, 1'b0, "rd_zero");
    check_val("rd_zero_const", read_data, 32'h0);

    // Simultaneous read and write: old value before the edge, new value after.
    step(1'b0, 14'd3, 32'hDEAD_BEEF, 1'b1, 1'b1, "rw_pre");
    #1;
    check_val("rw_post", read_data, 32'hDEAD_BEEF);

    // Write during reset is suppressed.
    step(1'b1, 14'd2, 32'h0000_1234, 1'b0, 1'b1, "rst_wr");
    step(1'b0, 14'd2, 32'h0, 1'b1, 1'b0, "rst_rd2");
`ifdef DMEM_RST_CLEAR_EN
    check_val("rst_rd2_const", read_data, 32'h0);
    step(1'b0, 14'd9, 32'h0, 1'b1, 1'b0, "rst_rd9");
    check_val("rst_rd9_const", read_data, 32'h0);
`else
    check_val("rst_rd2_const", read_data, 32'h4);
    step(1'b0, 14'd9, 32'h0, 1'b1, 1'b0, "rst_rd9");
    check_val("rst_rd9_const", read_data, 32'h12);
`endif

    // Randomized traffic over a small low window and a small top window.
    for (int n = 0; n < 400; n++) begin
      ra = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15))
                                      : AW'(DEPTH - 1 - $urandom_range(0, 15));
      rr  = ($urandom_range(0, 39) == 0);
      rw  = ($urandom_range(0, 1) == 1);
      rrd = ($urandom_range(0, 3) != 0);
      step(rr, ra, DW'($urandom), rrd, rw, "rand");
    end

    // Final sweep of both windows against the model.
    for (int a = 0; a < 16; a++) begin
      step(1'b0, AW'(a), 32'h0, 1'b1, 1'b0, "sweep_lo");
      step(1'b0, AW'(DEPTH - 1 - a), 32'h0, 1'b1, 1'b0, "sweep_hi");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_dmem
